input_port_controller: RTL and testbench

- Per-input-port front end of a mesh NoC router and initiator side of the switch-control reservation handshake.
- Buffers incoming flits in a FIFO and computes the XY output port from each head flit.
- Requests a path from the switch controller, streams the packet once the path is reserved, then relieves the path after the tail flit.
- One instance per router input port, between the upstream link and the crossbar.

---
 rtl/noc_pkg.sv | 56 +++++
 rtl/input_port_controller_if.sv | 32 +++
 rtl/flit_fifo.sv | 51 +++++
 rtl/input_port_controller.sv | 121 ++++++++++++
 tb/tb_input_port_controller.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit/port codes, controller states and XY routing.
package noc_pkg;

  localparam int unsigned FLIT_TYPE_WIDTH = 2;
  localparam int unsigned PORT_WIDTH      = 3;
  localparam int unsigned COORD_WIDTH     = 2;
  localparam int unsigned STATE_WIDTH     = 2;

  typedef enum logic [FLIT_TYPE_WIDTH-1:0] {
    FLIT_BODY      = 2'b00,
    FLIT_HEAD      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flitType_t;

  typedef enum logic [PORT_WIDTH-1:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_t;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_FORWARD = 2'd2,
    ST_RELEASE = 2'd3
  } ipcState_t;

  // Destination field carried in the low nibble of a head flit.
  typedef struct packed {
    logic [COORD_WIDTH-1:0] destY;
    logic [COORD_WIDTH-1:0] destX;
  } dest_t;

  function automatic logic isHeadType(input flitType_t t);
    return (t == FLIT_HEAD) || (t == FLIT_HEAD_TAIL);
  endfunction

  function automatic logic isTailType(input flitType_t t);
    return (t == FLIT_TAIL) || (t == FLIT_HEAD_TAIL);
  endfunction

  // Dimension-ordered routing: X is resolved completely before Y.
  function automatic port_t xyRoute(input dest_t dest,
                                    input logic [COORD_WIDTH-1:0] routerX,
                                    input logic [COORD_WIDTH-1:0] routerY);
    if (dest.destX > routerX)      return PORT_EAST;
    else if (dest.destX < routerX) return PORT_WEST;
    else if (dest.destY > routerY) return PORT_SOUTH;
    else if (dest.destY < routerY) return PORT_NORTH;
    else                           return PORT_LOCAL;
  endfunction

endpackage

// File: rtl/input_port_controller_if.sv
// Link, switch-control and crossbar signals of one router input port.
interface input_port_controller_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned REQUEST_WIDTH = 3
);
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     routeReserveRequestValid;
  logic [REQUEST_WIDTH-1:0] routeReserveRequest;
  logic                     routeRelieve;
  logic                     routeReserveStatus;
  logic                     PortReserved;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     drop_err;

  // Controller side.
  modport master (
    input  in_data, in_valid, routeReserveStatus, PortReserved, out_ready,
    output in_ready, routeReserveRequestValid, routeReserveRequest, routeRelieve,
           out_data, out_valid, drop_err
  );

  // Upstream link, switch control and crossbar side.
  modport slave (
    output in_data, in_valid, routeReserveStatus, PortReserved, out_ready,
    input  in_ready, routeReserveRequestValid, routeReserveRequest, routeRelieve,
           out_data, out_valid, drop_err
  );
endinterface

// File: rtl/flit_fifo.sv
// Circular flit buffer; depth must be a power of two so the pointers wrap naturally.
module flit_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic                            pop,
  input  logic [DATA_WIDTH-1:0]           wrData,
  output logic [DATA_WIDTH-1:0]           rdData,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH):0]     count
);
  localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wrPtr;
  logic [PTR_WIDTH-1:0]  rdPtr;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  doPush;
  logic                  doPop;

  assign full   = (cnt == CNT_WIDTH'(FIFO_DEPTH));
  assign empty  = (cnt == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];
  assign count  = cnt;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_WIDTH'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_WIDTH'(1);
      if (doPush && !doPop)      cnt <= cnt + CNT_WIDTH'(1);
      else if (doPop && !doPush) cnt <= cnt - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/input_port_controller.sv
// Router input port: buffers flits, XY-routes each head flit, reserves a crossbar
// path from switch control, streams the packet and relieves the path after the tail.
module input_port_controller
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned REQUEST_WIDTH = 3,
  parameter int unsigned ROUTER_X      = 0,
  parameter int unsigned ROUTER_Y      = 0
) (
  input logic                      clk,
  input logic                      rst,
  input_port_controller_if.master  bus
);

  ipcState_t                  state;
  logic [DATA_WIDTH-1:0]      headFlit;
  logic                       full;
  logic                       empty;
  logic [$clog2(FIFO_DEPTH):0] unusedFifoCount;
  flitType_t                  headType;
  dest_t                      headDest;
  port_t                      routePort;
  logic                       headIsHead;
  logic                       headIsTail;
  logic                       dropFlit;
  logic                       fwdValid;
  logic                       xfer;
  logic                       fifoPush;
  logic                       fifoPop;
  logic                       reqValid;
  logic [REQUEST_WIDTH-1:0]   reqPort;
  logic                       relieve;
  logic                       dropErr;
  logic                       unusedGrant;

  flit_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (fifoPush),
    .pop    (fifoPop),
    .wrData (bus.in_data),
    .rdData (headFlit),
    .full   (full),
    .empty  (empty),
    .count  (unusedFifoCount)
  );

  assign headType   = flitType_t'(headFlit[DATA_WIDTH-1 -: FLIT_TYPE_WIDTH]);
  assign headDest   = dest_t'(headFlit[2*COORD_WIDTH-1:0]);
  assign headIsHead = isHeadType(headType);
  assign headIsTail = isTailType(headType);
  assign routePort  = xyRoute(headDest, COORD_WIDTH'(ROUTER_X), COORD_WIDTH'(ROUTER_Y));

  // Grant pulse is informational; PortReserved alone gates forwarding.
  assign unusedGrant = bus.routeReserveStatus;

  // Stray body/tail flits at a packet boundary are discarded without a request.
  assign dropFlit = (state == ST_IDLE) && !empty && !headIsHead;
  // Forward valid depends only on registered state, never on out_ready.
  assign fwdValid = (state == ST_FORWARD) && !empty;
  assign xfer     = fwdValid && bus.out_ready;
  assign fifoPush = bus.in_valid && !full;
  assign fifoPop  = xfer || dropFlit;

  assign bus.in_ready                 = !full;
  assign bus.out_data                 = headFlit;
  assign bus.out_valid                = fwdValid;
  assign bus.routeReserveRequestValid = reqValid;
  assign bus.routeReserveRequest      = reqPort;
  assign bus.routeRelieve             = relieve;
  assign bus.drop_err                 = dropErr;

  // Controller FSM; the request port is only loaded on leaving IDLE, so it
  // stays frozen through REQUEST, FORWARD and RELEASE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      reqValid <= 1'b0;
      reqPort  <= '0;
      relieve  <= 1'b0;
      dropErr  <= 1'b0;
    end else begin
      relieve <= 1'b0;
      dropErr <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (headIsHead) begin
              reqPort  <= REQUEST_WIDTH'(routePort);
              reqValid <= 1'b1;
              state    <= ST_REQUEST;
            end else begin
              dropErr <= 1'b1;
            end
          end
        end
        ST_REQUEST: begin
          if (bus.PortReserved) state <= ST_FORWARD;
        end
        ST_FORWARD: begin
          if (xfer && headIsTail) begin
            reqValid <= 1'b0;
            relieve  <= 1'b1;
            state    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // One idle cycle follows so switch control can clear its busy flag.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_controller.sv
// Directed scoreboard bench for input_port_controller at router (1,1).
module tb_input_port_controller;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 3;
  localparam int          RX = 1;
  localparam int          RY = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  input_port_controller_if #(.DATA_WIDTH(DW), .REQUEST_WIDTH(RW)) bus ();

  input_port_controller #(
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (4),
    .REQUEST_WIDTH (RW),
    .ROUTER_X      (RX),
    .ROUTER_Y      (RY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests    = 0;
  int fails    = 0;
  int xfers    = 0;
  int relieves = 0;
  int drops    = 0;
  logic [DW-1:0] expQ [$];
  logic [RW-1:0] reqQ [$];
  logic [RW-1:0] curReq = '0;
  logic          prevReqValid = 1'b0;

  function automatic logic [RW-1:0] modelRoute(input logic [DW-1:0] f);
    int dx;
    int dy;
    dx = int'(f[1:0]);
    dy = int'(f[3:2]);
    if (dx > RX) return 3'd2;
    if (dx < RX) return 3'd4;
    if (dy > RY) return 3'd3;
    if (dy < RY) return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic [DW-1:0] flit(input logic [1:0] t, input int x, input int y);
    return {t, 2'b00, 2'(y), 2'(x)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes completing at this edge, then sample the results.
  task automatic cyc();
    logic [DW-1:0] d;
    if (rst && bus.in_valid && bus.in_ready) begin
      expQ.push_back(bus.in_data);
      if (bus.in_data[DW-2]) reqQ.push_back(modelRoute(bus.in_data));
    end
    if (rst && bus.out_valid && bus.out_ready) begin
      xfers++;
      check("out_queue_nonempty", 32'(expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        d = expQ.pop_front();
        check("out_data", bus.out_data, d);
      end
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      prevReqValid = 1'b0;
      return;
    end
    if (bus.routeRelieve) relieves++;
    if (bus.drop_err) begin
      drops++;
      check("drop_queue_nonempty", 32'(expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        d = expQ.pop_front();
        check("drop_is_nonhead", d[DW-2], 0);
      end
    end
    if (bus.routeReserveRequestValid && !prevReqValid) begin
      check("req_expected", 32'(reqQ.size() != 0), 1);
      if (reqQ.size() != 0) curReq = reqQ.pop_front();
      check("req_port", bus.routeReserveRequest, curReq);
    end else if (bus.routeReserveRequestValid) begin
      check("req_stable", bus.routeReserveRequest, curReq);
    end
    prevReqValid = bus.routeReserveRequestValid;
  endtask

  task automatic sendFlit(input logic [DW-1:0] f);
    bus.in_valid = 1'b1;
    bus.in_data  = f;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic waitReq(input int maxCycles);
    for (int i = 0; i < maxCycles && !bus.routeReserveRequestValid; i++) cyc();
    check("req_timeout", bus.routeReserveRequestValid, 1);
  endtask

  task automatic grant();
    bus.PortReserved       = 1'b1;
    bus.routeReserveStatus = 1'b1;
    cyc();
    bus.routeReserveStatus = 1'b0;
  endtask

  task automatic runUntilRelieve(input int maxCycles, input bit toggle);
    int r0;
    r0 = relieves;
    for (int i = 0; i < maxCycles && relieves == r0; i++) begin
      if (toggle) bus.out_ready = (i % 2 == 0);
      cyc();
    end
    check("relieve_once", relieves - r0, 1);
    check("relieve_req_valid_low", bus.routeReserveRequestValid, 0);
    check("relieve_out_valid_low", bus.out_valid, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_req_valid"}, bus.routeReserveRequestValid, 0);
    check({tag, "_req"}, bus.routeReserveRequest, 0);
    check({tag, "_relieve"}, bus.routeRelieve, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_drop_err"}, bus.drop_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int d0;
    bus.in_data            = flit(2'b01, 3, 0);
    bus.in_valid           = 1'b1;
    bus.routeReserveStatus = 1'b0;
    bus.PortReserved       = 1'b0;
    bus.out_ready          = 1'b0;

    // Reset with upstream valid asserted.
    rst = 1'b0;
    repeat (2) cyc();
    checkResetOutputs("reset");
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) cyc();
    check("post_reset_no_req", bus.routeReserveRequestValid, 0);
    check("post_reset_no_out", bus.out_valid, 0);

    // Single-flit packet to (1,2): SOUTH.
    bus.out_ready = 1'b1;
    x0 = xfers;
    sendFlit(8'hC9);
    waitReq(10);
    check("single_req_south", bus.routeReserveRequest, 3);
    repeat (3) cyc();
    check("single_no_fwd_before_grant", bus.out_valid, 0);
    grant();
    runUntilRelieve(10, 1'b0);
    bus.PortReserved = 1'b0;
    check("single_xfers", xfers - x0, 1);

    // Four-flit packet to x=3 with a toggling downstream ready: EAST.
    x0 = xfers;
    sendFlit(flit(2'b01, 3, 0));
    sendFlit(flit(2'b00, 1, 2));
    sendFlit(flit(2'b00, 2, 3));
    sendFlit(flit(2'b10, 3, 1));
    waitReq(10);
    check("multi_req_east", bus.routeReserveRequest, 2);
    grant();
    runUntilRelieve(20, 1'b1);
    bus.PortReserved = 1'b0;
    check("multi_xfers", xfers - x0, 4);
    bus.out_ready = 1'b1;
    repeat (2) cyc();
    check("multi_no_valid_after_tail", bus.out_valid, 0);

    // Contention: grant withheld for ten cycles while the FIFO fills.
    x0 = xfers;
    sendFlit(flit(2'b01, 1, 1));
    sendFlit(flit(2'b00, 2, 0));
    sendFlit(flit(2'b00, 0, 2));
    sendFlit(flit(2'b10, 3, 3));
    bus.in_valid = 1'b1;
    bus.in_data  = flit(2'b11, 0, 1);
    repeat (6) cyc();
    check("contention_full", bus.in_ready, 0);
    check("contention_req_held", bus.routeReserveRequestValid, 1);
    check("contention_req_local", bus.routeReserveRequest, 0);
    check("contention_no_out", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    grant();
    runUntilRelieve(20, 1'b0);
    bus.PortReserved = 1'b0;
    check("contention_xfers", xfers - x0, 4);
    check("contention_in_ready", bus.in_ready, 1);
    check("contention_drained", 32'(expQ.size()), 0);

    // Back-to-back packets: LOCAL then WEST with a one-cycle gap after relieve.
    sendFlit(flit(2'b11, 1, 1));
    sendFlit(flit(2'b11, 0, 1));
    waitReq(10);
    check("b2b_first_local", bus.routeReserveRequest, 0);
    grant();
    runUntilRelieve(10, 1'b0);
    bus.PortReserved = 1'b0;
    cyc();
    check("b2b_gap_no_req", bus.routeReserveRequestValid, 0);
    cyc();
    check("b2b_second_valid", bus.routeReserveRequestValid, 1);
    check("b2b_second_west", bus.routeReserveRequest, 4);
    grant();
    runUntilRelieve(10, 1'b0);
    bus.PortReserved = 1'b0;

    // Stray BODY flit at a packet boundary.
    d0 = drops;
    sendFlit(flit(2'b00, 2, 2));
    repeat (4) cyc();
    check("stray_drop_pulse", drops - d0, 1);
    check("stray_no_req", bus.routeReserveRequestValid, 0);
    check("stray_queue_empty", 32'(expQ.size()), 0);

    // Reset while forwarding mid-packet.
    bus.out_ready = 1'b0;
    sendFlit(flit(2'b01, 2, 1));
    sendFlit(flit(2'b00, 1, 1));
    waitReq(10);
    check("midfwd_req_east", bus.routeReserveRequest, 2);
    grant();
    check("midfwd_forwarding", bus.out_valid, 1);
    rst = 1'b0;
    cyc();
    checkResetOutputs("midfwd_reset");
    expQ.delete();
    reqQ.delete();
    rst = 1'b1;
    bus.PortReserved = 1'b0;
    repeat (3) cyc();
    check("midfwd_flushed_no_req", bus.routeReserveRequestValid, 0);
    check("midfwd_flushed_no_out", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
